bf_weight_loader: RTL
=====================

// Module: bf_weight_loader
// PURPOSE
//   Configuration controller for the 8-element, 2-beam phase-shift array.
//   Accepts a burst of beam weights (cos/sin per element per beam) over a
//   valid/ready stream into shadow registers, then commits all weights
//   atomically to the active outputs on a frame_sync strobe.
//   Active outputs drive the phaseShift w_cos_1/w_sin_1/w_cos_2/w_sin_2 inputs,
//   so weights never change mid-frame or partially.
// PARAMETERS
//   N_ELEM   8  number of array elements (DSM channels)
//   W_WIDTH  5  weight width, signed two's complement
// PORTS
//   clock       in   1                 system clock, rising edge
//   reset       in   1                 asynchronous, active-low reset
//   cfg_start   in   1                 1-cycle pulse: begin a new weight burst
//   cfg_abort   in   1                 abandon burst or pending commit
//   cfg_valid   in   1                 cfg_data/cfg_last valid
//   cfg_data    in   W_WIDTH           weight word
//   cfg_last    in   1                 marks final word of burst
//   cfg_ready   out  1                 loader accepts a word this cycle
//   frame_sync  in   1                 frame boundary strobe; commit point
//   w_cos_1     out  N_ELEM*W_WIDTH    beam 1 cos weights; element i at [i*W_WIDTH +: W_WIDTH]
//   w_sin_1     out  N_ELEM*W_WIDTH    beam 1 sin weights, same packing
//   w_cos_2     out  N_ELEM*W_WIDTH    beam 2 cos weights, same packing
//   w_sin_2     out  N_ELEM*W_WIDTH    beam 2 sin weights, same packing
//   busy        out  1                 state != IDLE
//   commit      out  1                 1-cycle pulse, cycle after active weights update
//   weights_ok  out  1                 at least one successful commit since reset
//   load_err    out  1                 last burst malformed; cleared by next cfg_start
// BEHAVIOUR
//   Reset (reset=0, async): state IDLE, word count k=0, shadow and all w_* = 0,
//     cfg_ready=0, busy=0, commit=0, weights_ok=0, load_err=0. All outputs registered.
//   Word order, K = 4*N_ELEM words, k = 0..K-1:
//     beam b = k / (2*N_ELEM) (0 -> beam 1), elem e = (k/2) % N_ELEM,
//     k even -> cos, k odd -> sin. Data passes through unmodified.
//   FSM states IDLE, LOAD, ARMED:
//     IDLE : cfg_ready=0. cfg_start -> LOAD, k<=0, load_err<=0.
//     LOAD : cfg_ready=1. Accept when cfg_valid & cfg_ready: shadow[k]<=cfg_data, k<=k+1.
//            Accept with cfg_last=1 and k==K-1 -> ARMED.
//            Accept with cfg_last=1 and k!=K-1 -> IDLE, load_err<=1.
//            Accept with k==K-1 and cfg_last=0 -> IDLE, load_err<=1.
//            cfg_abort -> IDLE, no error. Abort wins over an accept in the same cycle.
//            cfg_start ignored.
//     ARMED: cfg_ready=0. On the edge where frame_sync=1: all w_* <= shadow,
//            state -> IDLE, weights_ok<=1. commit=1 for the following cycle.
//            cfg_abort -> IDLE, no commit; abort wins over a simultaneous frame_sync.
//            cfg_start ignored.
//   Failed or aborted bursts never change w_*. Active weights change only at commit.
//   frame_sync in IDLE or LOAD is ignored, including in the cycle the last word is
//     accepted; commit needs a later frame_sync seen while in ARMED.
//   Latency: last word accepted at edge N -> earliest w_* update at edge N+1
//     (frame_sync high in cycle N+1); commit high in cycle N+2.
//   Shadow keeps stale words from partial bursts; a complete burst overwrites all K.
//   Reset mid-burst returns every output to 0 immediately, including active weights.
// TESTING
//   1 Reset: release reset -> all w_*=0, cfg_ready=0, busy=0, weights_ok=0, load_err=0.
//   2 Full load: start, send 32 words k -> (k-16) mod 32 with cfg_last on word 31,
//     then frame_sync -> w_cos_1[e]=2e-16, w_sin_2[7]=15; commit pulses once;
//     weights_ok=1; busy=0.
//   3 Backpressure/gaps: random cfg_valid idle cycles during the burst ->
//     same outputs as test 2; no word lost or duplicated.
//   4 Malformed burst: cfg_last on word 10 -> load_err=1, state IDLE, w_* unchanged.
//     Repeat with no cfg_last on word 31 -> load_err=1, w_* unchanged.
//   5 Commit timing and abort:
//     - frame_sync in the same cycle as the last word -> no update.
//     - Next frame_sync -> update.
//     - cfg_abort while ARMED, then frame_sync -> no update, no commit.
//   6 Reset mid-LOAD (word 20) after a prior commit -> all w_*=0, weights_ok=0.
//     A fresh full burst then commits correctly.

Source files
------------

// File: rtl/bf_weight_loader_if.sv
// Stream, commit strobe and weight outputs of the beam weight loader.
// The master side is the one that drives the configuration stream.
interface bf_weight_loader_if #(
  parameter int unsigned N_ELEM  = 8,
  parameter int unsigned W_WIDTH = 5
);
  logic                        cfg_start;
  logic                        cfg_abort;
  logic                        cfg_valid;
  logic [W_WIDTH-1:0]          cfg_data;
  logic                        cfg_last;
  logic                        cfg_ready;
  logic                        frame_sync;
  logic [N_ELEM*W_WIDTH-1:0]   w_cos_1;
  logic [N_ELEM*W_WIDTH-1:0]   w_sin_1;
  logic [N_ELEM*W_WIDTH-1:0]   w_cos_2;
  logic [N_ELEM*W_WIDTH-1:0]   w_sin_2;
  logic                        busy;
  logic                        commit;
  logic                        weights_ok;
  logic                        load_err;

  modport master (
    output cfg_start, cfg_abort, cfg_valid, cfg_data, cfg_last, frame_sync,
    input  cfg_ready, w_cos_1, w_sin_1, w_cos_2, w_sin_2,
           busy, commit, weights_ok, load_err
  );

  modport slave (
    input  cfg_start, cfg_abort, cfg_valid, cfg_data, cfg_last, frame_sync,
    output cfg_ready, w_cos_1, w_sin_1, w_cos_2, w_sin_2,
           busy, commit, weights_ok, load_err
  );
endinterface

// File: rtl/bf_weight_loader.sv
// Loads a burst of beam weights into shadow registers and commits them
// atomically to the active phase-shift weights on frame_sync.
module bf_weight_loader #(
  parameter int unsigned N_ELEM  = 8,
  parameter int unsigned W_WIDTH = 5
) (
  input  logic                   clock,
  input  logic                   reset,
  bf_weight_loader_if.slave      cfg
);

  localparam int unsigned K  = 4 * N_ELEM;
  localparam int unsigned KW = $clog2(K);

  typedef enum logic [1:0] {IDLE, LOAD, ARMED} state_t;

  state_t               state;
  logic [KW-1:0]        k;
  logic [W_WIDTH-1:0]   shadow [K];

  logic [N_ELEM*W_WIDTH-1:0] sh_cos_1, sh_sin_1, sh_cos_2, sh_sin_2;

  // Word k maps to beam k/(2*N_ELEM), element (k/2)%N_ELEM; even k is cos.
  for (genvar e = 0; e < N_ELEM; e++) begin : g_map
    assign sh_cos_1[e*W_WIDTH +: W_WIDTH] = shadow[2*e];
    assign sh_sin_1[e*W_WIDTH +: W_WIDTH] = shadow[2*e + 1];
    assign sh_cos_2[e*W_WIDTH +: W_WIDTH] = shadow[2*N_ELEM + 2*e];
    assign sh_sin_2[e*W_WIDTH +: W_WIDTH] = shadow[2*N_ELEM + 2*e + 1];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      k              <= '0;
      shadow         <= '{default: '0};
      cfg.w_cos_1    <= '0;
      cfg.w_sin_1    <= '0;
      cfg.w_cos_2    <= '0;
      cfg.w_sin_2    <= '0;
      cfg.cfg_ready  <= 1'b0;
      cfg.busy       <= 1'b0;
      cfg.commit     <= 1'b0;
      cfg.weights_ok <= 1'b0;
      cfg.load_err   <= 1'b0;
    end else begin
      cfg.commit <= 1'b0;
      case (state)
        IDLE: begin
          if (cfg.cfg_start) begin
            state         <= LOAD;
            k             <= '0;
            cfg.load_err  <= 1'b0;
            cfg.cfg_ready <= 1'b1;
            cfg.busy      <= 1'b1;
          end
        end
        LOAD: begin
          if (cfg.cfg_abort) begin
            state         <= IDLE;
            cfg.cfg_ready <= 1'b0;
            cfg.busy      <= 1'b0;
          end else if (cfg.cfg_valid) begin
            shadow[k] <= cfg.cfg_data;
            k         <= k + 1'b1;
            if (cfg.cfg_last && k == KW'(K - 1)) begin
              state         <= ARMED;
              cfg.cfg_ready <= 1'b0;
            end else if (cfg.cfg_last || k == KW'(K - 1)) begin
              state         <= IDLE;
              cfg.cfg_ready <= 1'b0;
              cfg.busy      <= 1'b0;
              cfg.load_err  <= 1'b1;
            end
          end
        end
        ARMED: begin
          if (cfg.cfg_abort) begin
            state    <= IDLE;
            cfg.busy <= 1'b0;
          end else if (cfg.frame_sync) begin
            state          <= IDLE;
            cfg.busy       <= 1'b0;
            cfg.w_cos_1    <= sh_cos_1;
            cfg.w_sin_1    <= sh_sin_1;
            cfg.w_cos_2    <= sh_cos_2;
            cfg.w_sin_2    <= sh_sin_2;
            cfg.weights_ok <= 1'b1;
            cfg.commit     <= 1'b1;
          end
        end
        default: begin
          state         <= IDLE;
          cfg.cfg_ready <= 1'b0;
          cfg.busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
